// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, register offsets and STATUS bit positions
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD = 2'd2;
  localparam int ST_BUSY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF = 3;
  localparam int ST_CNT = 4;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push to a full FIFO succeeds only alongside a pop
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and polled status
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic [31:0] addr,
  input  logic [31:0] memWdata,
  input  logic [3:0] memWMask,
  output logic [31:0] memRdata,
  output logic txd,
  output logic txIdle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_state_t state;
  logic sel, we, push, load, tick, full, empty, ovf, clr;
  logic [1:0] ridx;
  logic [7:0] shift, dout;
  logic [15:0] baud, div_l, bcnt, eff_div;
  logic [2:0] bitn;
  logic [CW-1:0] cnt;
  logic [31:0] status;
  logic unused;
  assign unused = ^{addr[1:0], memWdata[31:16], memWMask[3:2]};
  assign sel = addr[31:4] == BASE_ADDR[31:4];
  assign ridx = addr[3:2];
  assign we = sel && |memWMask;
  assign push = we && ridx == REG_TXDATA && memWMask[0];
  assign clr = we && ridx == REG_STATUS && memWMask[0] && memWdata[ST_OVF];
  assign eff_div = baud == '0 ? 16'd1 : baud;
  assign tick = bcnt == div_l - 16'd1;
  // a new frame starts from IDLE or straight out of a finishing STOP bit
  assign load = !empty && (state == IDLE || (state == STOP && tick));
  assign txd = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
  assign txIdle = empty && state == IDLE;

  sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .push(push), .pop(load), .din(memWdata[7:0]),
    .dout(dout), .full(full), .empty(empty), .count(cnt)
  );

  always_ff @(posedge clk)
    if (reset) begin
      baud <= 16'(CLKS_PER_BIT);
      ovf <= 1'b0;
    end else begin
      ovf <= (push && full && !load) || (ovf && !clr);
      if (we && ridx == REG_BAUD && memWMask[0]) baud[7:0] <= memWdata[7:0];
      if (we && ridx == REG_BAUD && memWMask[1]) baud[15:8] <= memWdata[15:8];
    end

  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      shift <= '0;
      div_l <= '0;
      bcnt <= '0;
      bitn <= '0;
    end else if (load) begin
      state <= START;
      shift <= dout;
      div_l <= eff_div;
      bcnt <= '0;
      bitn <= '0;
    end else if (state != IDLE) begin
      bcnt <= tick ? '0 : bcnt + 16'd1;
      if (tick && state == START) state <= DATA;
      if (tick && state == DATA) begin
        shift <= shift >> 1;
        bitn <= bitn + 3'd1;
        if (bitn == 3'd7) state <= STOP;
      end
      if (tick && state == STOP) state <= IDLE;
    end

  always_comb begin
    status = '0;
    status[ST_BUSY] = state != IDLE;
    status[ST_FULL] = full;
    status[ST_EMPTY] = empty;
    status[ST_OVF] = ovf;
    status[ST_CNT+:4] = 4'(cnt);
    memRdata = !sel ? '0 : ridx == REG_STATUS ? status : ridx == REG_BAUD ? {16'b0, baud} : '0;
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stores and polls; a txd monitor checks frames against a scoreboard
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0040_0000;
  typedef struct {logic [7:0] d; int div;} frame_t;
  logic clk = 0, reset = 1, txd, txIdle;
  logic [31:0] addr = '0, memWdata = '0, memRdata;
  logic [3:0] memWMask = '0;
  frame_t sb[$];
  int passed = 0, total = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(868), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .memWdata(memWdata), .memWMask(memWMask),
    .memRdata(memRdata), .txd(txd), .txIdle(txIdle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] m);
    addr = BASE + 32'(off);
    memWdata = d;
    memWMask = m;
    @(posedge clk);
    #1;
    memWMask = '0;
    addr = '0;
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    addr = BASE + 32'(off);
    #1;
    v = memRdata;
    addr = '0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int div);
    wr(4'h0, {24'h0, b}, 4'b0001);
    sb.push_back('{d: b, div: div});
  endtask

  task automatic wait_idle(input int lim, output int k);
    k = 0;
    while (!txIdle && k < lim) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  // frame monitor: every start bit pops one expectation and samples all 10*div cycles
  frame_t e;
  logic [9:0] obs;
  bit bad, ab;
  initial forever begin
    @(negedge clk);
    if (!reset && txd === 1'b0) begin
      if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        bad = 0;
        ab = 0;
        obs = '0;
        for (int i = 0; i < 10; i++)
          for (int j = 0; j < e.div; j++) begin
            if (i != 0 || j != 0) @(negedge clk);
            if (reset) ab = 1;
            if (j == 0) obs[i] = txd;
            else if (txd !== obs[i]) bad = 1;
          end
        if (!ab) chk("frame", {21'b0, bad, obs}, {21'b0, 1'b0, 1'b1, e.d, 1'b0});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] v;
  int k, gaps;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("rst_txd", 32'(txd), 32'd1);
    chk("rst_idle", 32'(txIdle), 32'd1);
    rd(4'h4, v); chk("rst_status", v, 32'h04);
    rd(4'h8, v); chk("rst_baud", v, 32'd868);
    rd(4'h0, v); chk("txdata_read", v, 32'd0);
    rd(4'hC, v); chk("reserved_read", v, 32'd0);
    addr = BASE + 32'h14; #1; chk("unselected", memRdata, 32'd0); addr = '0;

    wr(4'h8, 32'd4, 4'b0011);
    push_byte(8'hA5, 4);
    chk("no_bypass_txd", 32'(txd), 32'd1);
    @(posedge clk); #1;
    chk("latency_txd", 32'(txd), 32'd0);
    wait_idle(200, k);
    chk("frame_len", k + 1, 32'd41);

    push_byte(8'h55, 4);
    push_byte(8'h0F, 4);
    gaps = 0;
    for (int i = 0; i < 80; i++) begin
      rd(4'h4, v);
      if (!v[0] || txIdle) gaps++;
      @(posedge clk); #1;
    end
    chk("b2b_busy", gaps, 0);
    wait_idle(200, k);
    chk("b2b_done", 32'(txIdle), 32'd1);

    for (int i = 0; i < 5; i++) push_byte(8'h11 * (i + 1), 4);
    wr(4'h0, 32'h66, 4'b0001);
    rd(4'h4, v); chk("ovf_status", v, 32'h4B);
    wr(4'h4, 32'h8, 4'b0001);
    rd(4'h4, v); chk("ovf_clear", v, 32'h43);
    wait_idle(400, k);
    @(posedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    push_byte(8'h3C, 4);
    push_byte(8'hC3, 8);
    repeat (10) @(posedge clk);
    #1;
    wr(4'h8, 32'd8, 4'b0011);
    rd(4'h8, v); chk("baud8", v, 32'd8);
    wait_idle(400, k);
    chk("baud_change_done", 32'(txIdle), 32'd1);
    wr(4'h8, 32'd0, 4'b0011);
    rd(4'h8, v); chk("baud0", v, 32'd0);
    push_byte(8'h96, 1);
    wait_idle(100, k);
    chk("div0_len", k, 32'd11);
    @(posedge clk); #1;
    chk("sb_drained2", sb.size(), 0);

    wr(4'h8, 32'd4, 4'b0011);
    push_byte(8'hE7, 4);
    wr(4'h0, 32'h12, 4'b0001);
    wr(4'h0, 32'h34, 4'b0001);
    rd(4'h4, v); chk("queued2", v, 32'h21);
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    chk("reset_txd", 32'(txd), 32'd1);
    reset = 0;
    sb.delete();
    rd(4'h4, v); chk("post_rst_status", v, 32'h04);
    rd(4'h8, v); chk("post_rst_baud", v, 32'd868);
    gaps = 0;
    for (int i = 0; i < 60; i++) begin
      if (!txd || !txIdle) gaps++;
      @(posedge clk); #1;
    end
    chk("no_frames_after_rst", gaps, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
